// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: forwarding selects,
// load-use and branch handling, a data-memory wait/timeout FSM, and perf counters.
module pipeline_ctrl #(
    parameter int TIMEOUT   = 255,
    parameter int TO_WIDTH  = 8,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [4:0]           d_ra1,
    input  logic [4:0]           d_ra2,
    input  logic [4:0]           e_ra1,
    input  logic [4:0]           e_ra2,
    input  logic [4:0]           e_rd,
    input  logic [1:0]           e_resultsrc,
    input  logic                 e_pcsrc,
    input  logic [4:0]           m_rd,
    input  logic [4:0]           w_rd,
    input  logic                 m_regwrite,
    input  logic                 w_regwrite,
    input  logic                 m_memreq,
    input  logic                 dmem_ready,
    output logic                 f_stall,
    output logic                 d_stall,
    output logic                 e_stall,
    output logic                 m_stall,
    output logic                 d_flush,
    output logic                 e_flush,
    output logic                 w_flush,
    output logic [1:0]           e_fwd_a,
    output logic [1:0]           e_fwd_b,
    output logic                 mem_err,
    output logic [CNT_WIDTH-1:0] stall_cnt,
    output logic [CNT_WIDTH-1:0] flush_cnt
);

    typedef enum logic [1:0] {RUN, MEM_WAIT, ABORT} state_t;

    localparam logic [TO_WIDTH-1:0] TIMEOUT_W = TO_WIDTH'(TIMEOUT);

    state_t                state_q, state_d;
    logic [TO_WIDTH-1:0]   wait_cnt_q, wait_cnt_d;
    logic                  mem_err_q, mem_err_d;
    logic [CNT_WIDTH-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_WIDTH-1:0]  flush_cnt_q, flush_cnt_d;
    logic                  mem_stall;
    logic                  abort_flush;
    logic                  lw_hz;

    // M-stage result is newer than W, so it wins when both match.
    always_comb begin
        e_fwd_a = 2'b00;
        e_fwd_b = 2'b00;
        if (!rst) begin
            if (m_regwrite && m_rd != 5'd0 && m_rd == e_ra1)
                e_fwd_a = 2'b10;
            else if (w_regwrite && w_rd != 5'd0 && w_rd == e_ra1)
                e_fwd_a = 2'b01;
            if (m_regwrite && m_rd != 5'd0 && m_rd == e_ra2)
                e_fwd_b = 2'b10;
            else if (w_regwrite && w_rd != 5'd0 && w_rd == e_ra2)
                e_fwd_b = 2'b01;
        end
    end

    assign lw_hz = (e_resultsrc == 2'b01) && (e_rd != 5'd0) &&
                   ((e_rd == d_ra1) || (e_rd == d_ra2));

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        mem_err_d   = mem_err_q;
        mem_stall   = 1'b0;
        abort_flush = 1'b0;
        case (state_q)
            RUN: begin
                if (m_memreq && !dmem_ready) begin
                    mem_stall  = 1'b1;
                    state_d    = MEM_WAIT;
                    wait_cnt_d = TO_WIDTH'(1);
                end
            end
            MEM_WAIT: begin
                if (dmem_ready) begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q < TIMEOUT_W) begin
                    mem_stall  = 1'b1;
                    wait_cnt_d = wait_cnt_q + TO_WIDTH'(1);
                end else begin
                    mem_stall = 1'b1;
                    state_d   = ABORT;
                end
            end
            ABORT: begin
                abort_flush = 1'b1;
                mem_err_d   = 1'b1;
                state_d     = RUN;
                wait_cnt_d  = '0;
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    // A memory freeze overrides branch and load-use handling; E is held so those re-evaluate later.
    always_comb begin
        f_stall = 1'b0;
        d_stall = 1'b0;
        e_stall = 1'b0;
        m_stall = 1'b0;
        d_flush = 1'b0;
        e_flush = 1'b0;
        w_flush = 1'b0;
        if (rst) begin
            d_flush = 1'b1;
            e_flush = 1'b1;
            w_flush = 1'b1;
        end else if (mem_stall) begin
            f_stall = 1'b1;
            d_stall = 1'b1;
            e_stall = 1'b1;
            m_stall = 1'b1;
            w_flush = 1'b1;
        end else begin
            w_flush = abort_flush;
            if (e_pcsrc) begin
                d_flush = 1'b1;
                e_flush = 1'b1;
            end else if (lw_hz) begin
                f_stall = 1'b1;
                d_stall = 1'b1;
                e_flush = 1'b1;
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (f_stall)
            stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
        if (e_pcsrc && !mem_stall && !rst)
            flush_cnt_d = flush_cnt_q + CNT_WIDTH'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            wait_cnt_q  <= '0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_err_q   <= mem_err_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign mem_err   = mem_err_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Hazard and sequencing controller for the 5-stage pipeline. It computes execute-stage forwarding selects and detects load-use hazards. It generates stall (enable-low) and flush (synchronous clear) controls for the F, D, E, M and W pipeline registers. It also runs a small FSM that freezes the pipeline while the data memory is not ready, aborting the access after a bounded timeout. Two wrapping event counters, stall cycles and branch flushes, are provided for performance measurement.

## Interface
Parameters:
- TIMEOUT, 255: maximum MEM_WAIT cycles before an access is aborted.
- TO_WIDTH, 8: width of the wait counter; must hold TIMEOUT.
- CNT_WIDTH, 32: width of the performance counters.

Ports (single clock `clk`; synchronous, active-high `rst`):
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- d_ra1, d_ra2  in  5  decode-stage source registers.
- e_ra1, e_ra2, e_rd  in  5  execute-stage source and destination registers.
- e_resultsrc  in  2  execute-stage result source; 2'b01 means load.
- e_pcsrc  in  1  branch taken or jump resolved in execute.
- m_rd, w_rd  in  5  memory- and writeback-stage destination registers.
- m_regwrite, w_regwrite  in  1  destination-write enables.
- m_memreq  in  1  M stage holds a load or store.
- dmem_ready  in  1  data memory completes the access this cycle.
- f_stall, d_stall, e_stall, m_stall  out  1  hold the corresponding register or PC.
- d_flush, e_flush, w_flush  out  1  clear the corresponding register to a bubble.
- e_fwd_a, e_fwd_b  out  2  ALU operand select: 00 register file, 01 W result, 10 M ALU result.
- mem_err  out  1  sticky flag: a memory access timed out.
- stall_cnt  out  CNT_WIDTH  cycles with f_stall=1.
- flush_cnt  out  CNT_WIDTH  branch/jump flush events.

## Operation
- Forwarding is combinational. For operand a:
  - If m_regwrite && m_rd!=0 && m_rd==e_ra1, e_fwd_a=10.
  - Else if w_regwrite && w_rd!=0 && w_rd==e_ra1, e_fwd_a=01.
  - Else e_fwd_a=00.
  - e_fwd_b is identical using e_ra2. M takes priority over W.
- Load-use: lw_hz = (e_resultsrc==01) && e_rd!=0 && (e_rd==d_ra1 || e_rd==d_ra2).
- Memory FSM states: RUN, MEM_WAIT, ABORT. wait_cnt is TO_WIDTH bits.
  - RUN, m_memreq && !dmem_ready: mem_stall=1; go to MEM_WAIT with wait_cnt<=1.
  - MEM_WAIT, dmem_ready: mem_stall=0; go to RUN with wait_cnt<=0.
  - MEM_WAIT, !dmem_ready, wait_cnt<TIMEOUT: mem_stall=1; wait_cnt++.
  - MEM_WAIT, !dmem_ready, wait_cnt==TIMEOUT: mem_stall=1; go to ABORT.
  - ABORT: mem_stall=0; w_flush=1 (the faulting access is dropped); mem_err<=1; go to RUN, wait_cnt<=0.
  - A miss in RUN therefore stalls for TIMEOUT+1 cycles before ABORT.
- Output priority, highest first:
  1. mem_stall: f/d/e/m_stall=1, w_flush=1, d_flush=e_flush=0. e_pcsrc and lw_hz are ignored; E is frozen, so they re-evaluate on release.
  2. e_pcsrc: d_flush=1, e_flush=1, no stalls; overrides lw_hz.
  3. lw_hz: f_stall=1, d_stall=1, e_flush=1.
  4. Otherwise: all stall/flush outputs are 0, except w_flush=1 in ABORT.
- Counters:
  - stall_cnt increments every non-reset cycle with f_stall=1.
  - flush_cnt increments every cycle with e_pcsrc && !mem_stall.
  - Both wrap modulo 2^CNT_WIDTH.

## Timing
- Stall, flush and forward outputs are combinational from inputs and current state, with no added latency.
- Registered state is the FSM state, wait_cnt, mem_err, stall_cnt and flush_cnt.
- Reset values: state=RUN, wait_cnt=0, mem_err=0, stall_cnt=0, flush_cnt=0.
- While rst=1:
  - All stalls=0; d_flush=e_flush=w_flush=1; e_fwd_a=e_fwd_b=00.
  - Counters do not count.
- Reset asserted in MEM_WAIT or ABORT returns the FSM to RUN on the next edge. mem_err clears only on reset.
- A load-use hazard costs exactly one bubble. A taken branch costs two squashed instructions.
- dmem_ready=1 in the same cycle as a RUN-state request: no stall, and the FSM stays in RUN.

## Test plan
- Forwarding:
  - m_regwrite=1, m_rd=5, w_regwrite=1, w_rd=5, e_ra1=5 -> e_fwd_a=10.
  - Set m_regwrite=0 -> e_fwd_a=01.
  - e_ra2=0 with m_rd=0 -> e_fwd_b=00.
- Load-use: e_resultsrc=01, e_rd=7, d_ra2=7 for one cycle -> f_stall=d_stall=e_flush=1 for that cycle only; stall_cnt goes 0->1.
- Branch beats load-use: e_pcsrc=1 together with lw_hz -> d_flush=e_flush=1, f_stall=0; flush_cnt +1.
- Memory wait: m_memreq=1, dmem_ready low for 3 cycles then high -> all stalls=1 and w_flush=1 for 3 cycles, then 0; state returns to RUN; stall_cnt=3.
- Timeout with TIMEOUT=4 and dmem_ready held 0:
  - 5 stall cycles, then an ABORT cycle with stall=0 and w_flush=1.
  - mem_err=1 thereafter; e_pcsrc during the stall does not increment flush_cnt.
- Reset mid-wait: rst=1 in MEM_WAIT -> next cycle state=RUN, mem_err=0, counters=0; flush outputs are 1 while rst is held.
